// File: rtl/mips_defs.sv
// Shared MIPS writeback definitions: zero register, default widths, requester indices.
package mips_defs;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MDU = 1'b1;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with valid/ready intake; drained by an external grant.
module wb_hold_buf
    import mips_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    // A grant frees the slot in the same cycle, so a streaming requester never stalls.
    assign o_ready  = ~r_full | i_grant;
    assign w_accept = i_valid & o_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
        end else if (i_grant) begin
            r_full <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while r_full is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= i_addr;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback buffers onto the register-file write port through a registered stage.
// Optional macro REGFILE_ARB_RR_EN selects round-robin tie-break; otherwise requester 0 has fixed priority.
module regfile_write_arbiter
    import mips_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    output logic              busy
);

    logic              w_full0;
    logic              w_full1;
    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;
    logic [DATA_W-1:0] w_data0;
    logic [DATA_W-1:0] w_data1;
    logic              w_grant0;
    logic              w_grant1;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_we3;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd3;

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf0 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (req0_valid),
        .i_addr  (req0_addr),
        .i_data  (req0_data),
        .i_grant (w_grant0),
        .o_ready (req0_ready),
        .o_full  (w_full0),
        .o_addr  (w_addr0),
        .o_data  (w_data0)
    );

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf1 (
        .clk     (clk),
        .reset   (reset),
        .i_valid (req1_valid),
        .i_addr  (req1_addr),
        .i_data  (req1_data),
        .i_grant (w_grant1),
        .o_ready (req1_ready),
        .o_full  (w_full1),
        .o_addr  (w_addr1),
        .o_data  (w_data1)
    );

`ifdef REGFILE_ARB_RR_EN
    logic r_last;

    // Reset to REQ_MDU so the first tie goes to the ALU requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= REQ_MDU;
        end else if (w_grant0) begin
            r_last <= REQ_ALU;
        end else if (w_grant1) begin
            r_last <= REQ_MDU;
        end
    end

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_grant0 = w_full0;
        w_grant1 = w_full1 & ~w_full0;
        if (w_full0 && w_full1) begin
            w_grant0 = (r_last == REQ_MDU);
            w_grant1 = (r_last == REQ_ALU);
        end
    end
`else
    always_comb begin
        w_grant0 = w_full0;
        w_grant1 = w_full1 & ~w_full0;
    end
`endif

    assign w_sel_addr = w_grant0 ? w_addr0 : w_addr1;
    assign w_sel_data = w_grant0 ? w_data0 : w_data1;

    // Writes to $0 still move a3/wd3 but never raise the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_we3 <= (w_sel_addr != ADDR_W'(REG_ZERO));
            r_a3  <= w_sel_addr;
            r_wd3 <= w_sel_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign we3  = r_we3;
    assign a3   = r_a3;
    assign wd3  = r_wd3;
    assign busy = w_full0 | w_full1 | r_we3;

endmodule
